seq_comparator: RTL and testbench



---
 rtl/cmp_pkg.sv | 30 +++
 rtl/slice_cmp.sv | 39 +++
 rtl/seq_comparator.sv | 141 ++++++++++++++
 tb/tb_seq_comparator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// ----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the sliced magnitude comparator.
//   state_t       : FSM encoding (IDLE / CMP / DONE)
//   CMP_GT/EQ/LT  : one-hot result codes laid out as {gt, eq, lt}
//   encode_result : maps a slice gt/lt pair to the result code
// ----------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  // gt and lt are never both high for a single slice, so gt wins by default
  function automatic logic [2:0] encode_result(input logic gt, input logic lt);
    if (gt)
      return CMP_GT;
    else if (lt)
      return CMP_LT;
    else
      return CMP_EQ;
  endfunction

endpackage

// File: rtl/slice_cmp.sv
// ----------------------------------------------------------------------------
// slice_cmp
// Purely combinational SLICE-bit magnitude comparator.
//   x, y       : slice operands
//   signed_top : treat this slice as the sign-carrying top slice of a
//                two's-complement operand
//   gt, lt     : x > y, x < y (both low when equal)
// ----------------------------------------------------------------------------
module slice_cmp #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             signed_top,
  output logic             gt,
  output logic             lt
);

  logic [SLICE-1:0] xs;
  logic [SLICE-1:0] ys;

  // Flipping the sign bit maps two's-complement ordering onto unsigned
  // ordering, so a single unsigned comparator serves both modes.
  always_comb begin
    xs = x;
    ys = y;
    if (signed_top) begin
      xs[SLICE-1] = ~x[SLICE-1];
      ys[SLICE-1] = ~y[SLICE-1];
    end
  end

  // Plain unsigned compare of the (possibly sign-adjusted) slices
  always_comb begin
    gt = (xs > ys);
    lt = (xs < ys);
  end

endmodule

// File: rtl/seq_comparator.sv
// ----------------------------------------------------------------------------
// seq_comparator
// Multi-cycle magnitude comparator: compares WIDTH-bit operands SLICE bits
// per cycle, MSB slice first, stopping at the first differing slice.
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : a, b, signed_mode valid       in_ready : idle, accepting
//   a, b         : operands                      signed_mode : 1 = signed
//   out_valid    : result valid                  out_ready   : result taken
//   out          : {gt, eq, lt} one-hot result
//   cycles       : number of slices examined for this result
// ----------------------------------------------------------------------------
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  input  logic                              signed_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [2:0]                        out,
  output logic [$clog2(WIDTH/SLICE+1)-1:0]  cycles
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE + 1);
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int NPAD   = 2 ** IW;

  // Operands must split into whole slices
  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("seq_comparator: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IW-1:0]    idx;
  logic [SLICE-1:0] a_sl [NPAD];
  logic [SLICE-1:0] b_sl [NPAD];
  logic             sl_gt;
  logic             sl_lt;
  logic             sl_signed;
  logic             last_slice;

  // Split the registered operands into an idx-addressable slice table.
  // The table is padded to a power of two so every idx value is in range.
  generate
    for (genvar i = 0; i < NPAD; i++) begin : g_slices
      if (i < NSLICE) begin : g_real
        assign a_sl[i] = a_q[i*SLICE +: SLICE];
        assign b_sl[i] = b_q[i*SLICE +: SLICE];
      end else begin : g_pad
        assign a_sl[i] = '0;
        assign b_sl[i] = '0;
      end
    end
  endgenerate

  assign last_slice = (idx == '0);
  assign sl_signed  = signed_q && (idx == IW'(NSLICE - 1));

  slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
    .x          (a_sl[idx]),
    .y          (b_sl[idx]),
    .signed_top (sl_signed),
    .gt         (sl_gt),
    .lt         (sl_lt)
  );

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state: accept in IDLE, scan slices in CMP until a difference or
  // slice 0, then hold the result in DONE until the consumer takes it
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = CMP;
      CMP:  if (sl_gt || sl_lt || last_slice) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture at accept, slice walk and result latch.
  // out and cycles are only written in CMP, so they stay put through DONE
  // and afterwards, apart from cycles being cleared at the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= IW'(NSLICE - 1);
      cycles   <= '0;
      out      <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx      <= IW'(NSLICE - 1);
            cycles   <= '0;
          end
        end
        CMP: begin
          cycles <= cycles + CW'(1);
          if (sl_gt || sl_lt || last_slice)
            out <= encode_result(sl_gt, sl_lt);
          else
            idx <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// ----------------------------------------------------------------------------
// tb_seq_comparator
// Scoreboard bench for seq_comparator (WIDTH = 32, SLICE = 8). The driver
// pushes the expected result of every accepted operation; an independent
// monitor pops and compares whenever the DUT presents a result.
// ----------------------------------------------------------------------------
module tb_seq_comparator;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  typedef struct {
    logic [2:0] res;
    logic [2:0] cyc;
    int         acc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              signed_mode;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        res;
  logic [2:0]        cyc_o;

  int   checks = 0;
  int   errors = 0;
  int   edge_count = 0;
  int   hs_edge = -10;
  int   ready_mode = 0;
  exp_t sbq[$];
  exp_t cur;
  logic prev_valid = 1'b0;
  logic [2:0] held_res;
  logic [2:0] held_cyc;

  seq_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (res),
    .cycles      (cyc_o)
  );

  // Free-running clock and an edge counter used for latency checks
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_count <= edge_count + 1;

  // Hard stop so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Consumer: always ready, random, or held low, changed just after posedge
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Reference: whole-word compare on integers; slices examined is set by the
  // highest differing bit, or all slices when the operands are equal
  function automatic exp_t refModel(input logic [WIDTH-1:0] ta,
                                    input logic [WIDTH-1:0] tb,
                                    input logic tsm);
    exp_t e;
    logic [WIDTH-1:0] diff;
    longint va, vb;
    int hi;
    va = tsm ? longint'($signed(ta)) : longint'({32'd0, ta});
    vb = tsm ? longint'($signed(tb)) : longint'({32'd0, tb});
    if (va > vb)      e.res = 3'b100;
    else if (va < vb) e.res = 3'b001;
    else              e.res = 3'b010;
    diff = ta ^ tb;
    hi = -1;
    for (int i = 0; i < WIDTH; i++) if (diff[i]) hi = i;
    e.cyc = (hi < 0) ? 3'(NSLICE) : 3'(NSLICE - hi / SLICE);
    e.acc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present one operation (called at a negedge) and hold it until accepted
  task automatic applyStimulus(input logic [WIDTH-1:0] ta,
                               input logic [WIDTH-1:0] tb,
                               input logic tsm);
    exp_t e;
    int waitc = 0;
    a = ta;
    b = tb;
    signed_mode = tsm;
    in_valid = 1'b1;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      e = refModel(ta, tb, tsm);
      e.acc = edge_count + 1;
      if (waitc > 0)
        checkOutput("accept_after_handshake", 32'(e.acc), 32'(hs_edge + 1));
      sbq.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out"}, 32'(res), 32'd0);
    checkOutput({tag, "_cycles"}, 32'(cyc_o), 32'd0);
  endtask

  // Monitor: pop on each new result, check value and latency, then check
  // that the result and in_ready stay stable while it is held
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_result", 32'(sbq.size()), 32'd1);
        end else begin
          cur = sbq.pop_front();
          checkOutput("result", 32'(res), 32'(cur.res));
          checkOutput("cycles", 32'(cyc_o), 32'(cur.cyc));
          checkOutput("latency", 32'(edge_count - cur.acc), 32'(cur.cyc));
          held_res = res;
          held_cyc = cyc_o;
        end
      end else if (out_valid) begin
        checkOutput("hold_out", 32'(res), 32'(held_res));
        checkOutput("hold_cycles", 32'(cyc_o), 32'(held_cyc));
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) hs_edge = edge_count + 1;
      prev_valid = out_valid;
    end
  end

  task automatic drain();
    int w = 0;
    while ((sbq.size() != 0 || out_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drained", 32'(sbq.size()), 32'd0);
  endtask

  // Main sequence: reset, directed cases, backpressure, random, mid-reset
  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleReset("reset");
    #1 rst = 1'b0;
    @(negedge clk);
    checkIdleReset("post_reset");

    applyStimulus(32'h19000000, 32'h0A000000, 1'b0);
    applyStimulus(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0);
    applyStimulus(32'h00000005, 32'h00000014, 1'b0);
    applyStimulus(32'h80000000, 32'h00000000, 1'b1);
    applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b1);
    drain();

    $display("[TB] backpressure");
    ready_mode = 2;
    applyStimulus(32'h12340000, 32'h12350000, 1'b0);
    fork
      applyStimulus(32'hCAFE0001, 32'hCAFE0001, 1'b1);
      begin
        int w = 0;
        while (!out_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        repeat (5) @(negedge clk);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        ready_mode = 0;
      end
    join
    drain();

    $display("[TB] random");
    ready_mode = 1;
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        default: rb = ra ^ 32'h80000000;
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    ready_mode = 0;
    drain();

    $display("[TB] reset mid-compare");
    applyStimulus(32'h12345678, 32'h12345678, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkIdleReset("mid_reset");
    applyStimulus(32'h00000002, 32'h00000002, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
